// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream arbitration slice.
package axis_pkg;

  localparam int AXIS_DATA_W      = 32;
  localparam int AXIS_MAX_MASTERS = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: the requester after `last` (cyclically)
// wins; implemented as rotate, isolate lowest set bit, rotate back.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic             any
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_gnt;

  // Bit i of rot is the requester i+1 places after the previous winner.
  always_comb begin
    logic [IDX_W-1:0] idx;
    rot = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx    = IDX_W'((int'(last) + 1 + i) % N);
      rot[i] = req[idx];
    end
  end

  assign rot_gnt = rot & (~rot + {{(N-1){1'b0}}, 1'b1});

  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx      = IDX_W'((int'(last) + 1 + i) % N);
      gnt[idx] = rot_gnt[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream slave between
// N_MASTERS upstream masters; grant is held until the tlast handshake.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = AXIS_DATA_W,
  parameter int CNT_W     = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_MASTERS-1:0]        s_tvalid,
  output logic [N_MASTERS-1:0]        s_tready,
  input  logic [N_MASTERS*DATA_W-1:0] s_tdata,
  input  logic [N_MASTERS-1:0]        s_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tlast,
  output logic [N_MASTERS-1:0]        grant,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int IDX_W = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > AXIS_MAX_MASTERS) begin : g_bad_n
    $error("axis_rr_arbiter: N_MASTERS out of range");
  end

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [N_MASTERS-1:0] pick_gnt;
  logic                 pick_any;
  logic [IDX_W-1:0]     g_idx;
  logic                 hs;

  rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req  (s_tvalid),
    .last (last_q),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  // Only the registered grant steers the mux, so s_tready never depends on s_tvalid.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    g_idx    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        m_tvalid    = s_tvalid[i];
        m_tdata     = s_tdata[i*DATA_W +: DATA_W];
        m_tlast     = s_tlast[i];
        s_tready[i] = m_tready;
        g_idx       = IDX_W'(i);
      end
    end
  end

  assign hs = m_tvalid & m_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (hs && m_tlast) begin
          grant_d = '0;
          last_d  = g_idx;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == ST_GRANT);
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: a packet-level reference model pushes
// expected beats, an independent monitor pops and compares on each handshake.
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]    s_tlast = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic [N-1:0]    grant;
  logic            busy;
  logic [CW-1:0]   pkt_count;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          src;
  } beat_t;
  beat_t sb_q[$];

  logic [N-1:0] exp_grant = '0;
  logic [N-1:0] exp_tready = '0;
  logic         exp_mvalid = 1'b0;
  int           exp_cnt = 0;

  int pkt_len[N];
  int beat_no[N];
  int pkt_no[N];

  axis_rr_arbiter #(.N_MASTERS(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 aclk = ~aclk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] mk(input logic [31:0] d0, input logic [31:0] d1,
                                         input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Reference model: packet-level arbitration rules with a plain integer owner and pointer.
  initial begin : model
    int mg;
    int mlast;
    int mcnt;
    mg = -1;
    mlast = N - 1;
    mcnt = 0;
    forever begin
      @(negedge aclk);
      #2;
      exp_grant  = '0;
      exp_tready = '0;
      exp_mvalid = 1'b0;
      exp_cnt    = mcnt;
      if (mg >= 0) begin
        exp_grant[mg]  = 1'b1;
        exp_mvalid     = s_tvalid[mg];
        exp_tready[mg] = m_tready;
        if (s_tvalid[mg] && m_tready)
          sb_q.push_back('{s_tdata[mg*DW +: DW], s_tlast[mg], mg});
      end
      if (areset) begin
        mg = -1;
        mlast = N - 1;
        mcnt = 0;
      end else if (mg < 0) begin
        for (int k = 1; k <= N; k++)
          if (mg < 0 && s_tvalid[(mlast + k) % N]) mg = (mlast + k) % N;
      end else if (s_tvalid[mg] && m_tready && s_tlast[mg]) begin
        mcnt = (mcnt + 1) % (1 << CW);
        mlast = mg;
        mg = -1;
      end
    end
  end

  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge aclk);
      #3;
      if (checking) begin
        check_output("grant", 32'(grant), 32'(exp_grant));
        check_output("busy", 32'(busy), 32'(exp_grant != '0));
        check_output("pkt_count", 32'(pkt_count), exp_cnt);
        check_output("s_tready", 32'(s_tready), 32'(exp_tready));
        check_output("m_tvalid", 32'(m_tvalid), 32'(exp_mvalid));
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
          hs_count++;
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_unexpected_beat: got beat 0x%0h expected no beat at %0t", m_tdata, $time);
          end else begin
            b = sb_q.pop_front();
            check_output("sb_data", m_tdata, b.data);
            check_output("sb_last", 32'(m_tlast), 32'(b.last));
            check_output("sb_src", 32'(grant), 32'(1 << b.src));
          end
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] tv, input logic [N-1:0] tl,
                       input logic [N*DW-1:0] td, input logic rdy, input logic rst = 1'b0);
    @(negedge aclk);
    areset   = rst;
    s_tvalid = tv;
    s_tlast  = tl;
    s_tdata  = td;
    m_tready = rdy;
    #3;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset   = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    #3;
  endtask

  // Random masters: each sends packets of 1..4 beats, tvalid toggling at random.
  task automatic apply_stimulus(input int cycles, input int vpct, input int rpct, input logic [N-1:0] en);
    for (int c = 0; c < cycles; c++) begin
      @(negedge aclk);
      areset   = 1'b0;
      m_tready = ($urandom_range(99) < rpct);
      for (int i = 0; i < N; i++) begin
        s_tvalid[i] = en[i] && ($urandom_range(99) < vpct);
        s_tdata[i*DW +: DW] = {8'(i), 8'(pkt_no[i]), 16'(beat_no[i])};
        s_tlast[i] = (beat_no[i] == pkt_len[i] - 1);
      end
      #3;
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          if (s_tlast[i]) begin
            pkt_no[i]++;
            beat_no[i] = 0;
            pkt_len[i] = $urandom_range(4, 1);
          end else begin
            beat_no[i]++;
          end
        end
      end
    end
  endtask

  initial begin : stimulus
    int hs0;
    checking = 1'b1;
    for (int i = 0; i < N; i++) begin
      pkt_len[i] = $urandom_range(4, 1);
      beat_no[i] = 0;
      pkt_no[i]  = 0;
    end

    do_reset();
    check_output("rst_grant", 32'(grant), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_pkt_count", 32'(pkt_count), 32'h0);
    check_output("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    check_output("rst_s_tready", 32'(s_tready), 32'h0);
    check_output("rst_m_tdata", m_tdata, 32'h0);

    // Single requester, three-beat packet.
    drive(4'b0100, 4'b0000, mk(0, 0, 32'hA0, 0), 1'b1);
    check_output("t1_latency", 32'(grant), 32'h0);
    drive(4'b0100, 4'b0000, mk(0, 0, 32'hA0, 0), 1'b1);
    check_output("t1_grant", 32'(grant), 32'b0100);
    check_output("t1_beat0", m_tdata, 32'hA0);
    drive(4'b0100, 4'b0000, mk(0, 0, 32'hA1, 0), 1'b1);
    check_output("t1_beat1", m_tdata, 32'hA1);
    drive(4'b0100, 4'b0100, mk(0, 0, 32'hA2, 0), 1'b1);
    check_output("t1_beat2", m_tdata, 32'hA2);
    check_output("t1_tlast", 32'(m_tlast), 32'h1);
    drive(4'b0000, 4'b0000, '0, 1'b1);
    check_output("t1_release", 32'(grant), 32'h0);
    check_output("t1_count", 32'(pkt_count), 32'h1);

    // All masters streaming single-beat packets.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(4'b1111, 4'b1111, mk(32'h100 + k, 32'h200 + k, 32'h300 + k, 32'h400 + k), 1'b1);
      check_output("t2_grant_order", 32'(grant), (k % 2 == 1) ? (32'h1 << ((k / 2) % 4)) : 32'h0);
    end
    drive(4'b0000, 4'b0000, '0, 1'b1);
    check_output("t2_count", 32'(pkt_count), 32'h6);

    // Back-pressure on master 1 mid-packet.
    hs0 = hs_count;
    drive(4'b0010, 4'b0000, mk(0, 32'hB0, 0, 0), 1'b1);
    drive(4'b0010, 4'b0000, mk(0, 32'hB0, 0, 0), 1'b1);
    check_output("t3_grant", 32'(grant), 32'b0010);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0010, 4'b0000, mk(0, 32'hB1, 0, 0), 1'b0);
      check_output("t3_stall_data", m_tdata, 32'hB1);
      check_output("t3_stall_ready", 32'(s_tready[1]), 32'h0);
    end
    drive(4'b0010, 4'b0000, mk(0, 32'hB1, 0, 0), 1'b1);
    drive(4'b0010, 4'b0010, mk(0, 32'hB2, 0, 0), 1'b1);
    drive(4'b0000, 4'b0000, '0, 1'b1);
    check_output("t3_beats", hs_count - hs0, 32'h3);

    // Master 0 pauses mid-packet while master 3 waits.
    drive(4'b0001, 4'b1000, mk(32'hC0, 0, 0, 32'hD0), 1'b1);
    drive(4'b1001, 4'b1000, mk(32'hC0, 0, 0, 32'hD0), 1'b1);
    check_output("t4_grant", 32'(grant), 32'b0001);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1000, 4'b1000, mk(32'hC1, 0, 0, 32'hD0), 1'b1);
      check_output("t4_hold_grant", 32'(grant), 32'b0001);
      check_output("t4_m3_ready", 32'(s_tready[3]), 32'h0);
    end
    drive(4'b1001, 4'b1001, mk(32'hC1, 0, 0, 32'hD0), 1'b1);
    check_output("t4_tail_data", m_tdata, 32'hC1);
    drive(4'b1000, 4'b1000, mk(0, 0, 0, 32'hD0), 1'b1);
    check_output("t4_gap", 32'(grant), 32'h0);
    drive(4'b1000, 4'b1000, mk(0, 0, 0, 32'hD0), 1'b1);
    check_output("t4_m3_grant", 32'(grant), 32'b1000);
    drive(4'b0000, 4'b0000, '0, 1'b1);

    // Reset during the second beat of a four-beat packet.
    drive(4'b0010, 4'b0000, mk(0, 32'hE0, 0, 0), 1'b1);
    drive(4'b0010, 4'b0000, mk(0, 32'hE0, 0, 0), 1'b1);
    drive(4'b0010, 4'b0000, mk(0, 32'hE1, 0, 0), 1'b1, 1'b1);
    drive(4'b1010, 4'b1010, mk(0, 32'hF1, 0, 32'hF3), 1'b1);
    check_output("t5_grant", 32'(grant), 32'h0);
    check_output("t5_busy", 32'(busy), 32'h0);
    check_output("t5_count", 32'(pkt_count), 32'h0);
    check_output("t5_m_tvalid", 32'(m_tvalid), 32'h0);
    drive(4'b1010, 4'b1010, mk(0, 32'hF1, 0, 32'hF3), 1'b1);
    check_output("t5_m1_first", 32'(grant), 32'b0010);
    drive(4'b1000, 4'b1000, mk(0, 0, 0, 32'hF3), 1'b1);
    drive(4'b1000, 4'b1000, mk(0, 0, 0, 32'hF3), 1'b1);
    check_output("t5_m3_next", 32'(grant), 32'b1000);
    drive(4'b0000, 4'b0000, '0, 1'b1);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      if (k < 32) drive(4'b0001, 4'b0001, mk(32'h500 + k, 0, 0, 0), 1'b1);
      else        drive(4'b0000, 4'b0000, '0, 1'b1);
      if (k == 30) check_output("wrap_15", 32'(pkt_count), 32'hF);
      if (k == 32) check_output("wrap_0", 32'(pkt_count), 32'h0);
    end

    apply_stimulus(3000, 70, 70, 4'b1111);
    apply_stimulus(2000, 40, 90, 4'b1011);
    for (int k = 0; k < 3; k++) drive(4'b0000, 4'b0000, '0, 1'b0);
    check_output("sb_drain", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream AXI-Stream slave (e.g. the single-beat receiver feeding the datapath) between N upstream AXI-Stream masters.
- Grants one master at a time and holds the grant until that master's tlast beat handshakes. It then rotates priority.
- Muxes the granted master's tdata/tlast/tvalid to the downstream port and routes downstream tready back to the granted master only.
- Sits between the stream sources and the shared slave; also exports grant and packet-count status.

Parameters:
- N_MASTERS, 4, number of upstream masters (2..8).
- DATA_W, 32, tdata width in bits.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_tvalid  in  N_MASTERS  per-master tvalid.
- s_tready  out  N_MASTERS  per-master tready.
- s_tdata  in  N_MASTERS*DATA_W  per-master tdata; master i occupies bits [i*DATA_W +: DATA_W].
- s_tlast  in  N_MASTERS  per-master tlast.
- m_tvalid  out  1  downstream tvalid.
- m_tready  in  1  downstream tready.
- m_tdata  out  DATA_W  downstream tdata.
- m_tlast  out  1  downstream tlast.
- grant  out  N_MASTERS  one-hot registered grant; all-zero when idle.
- busy  out  1  high while a grant is held.
- pkt_count  out  CNT_W  number of completed packets (tlast handshakes), wrapping.

Behaviour:
- Interface: one clock, aclk. Reset is areset: synchronous, active-high.
- Reset values:
  - grant=0, busy=0, pkt_count=0.
  - Round-robin pointer last=N_MASTERS-1, so master 0 has top priority after reset.
  - s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - Outputs are quiescent: m_tvalid=0 and all s_tready=0.
  - If any s_tvalid is high, select the first requester scanning last+1, last+2, … modulo N_MASTERS.
  - Register grant, set busy, go to GRANT. Arbitration latency is 1 cycle from tvalid to grant.
- GRANT, for granted index g:
  - Combinational mux: m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g].
  - s_tready[g]=m_tready; all other s_tready=0.
  - Handshake condition is m_tvalid & m_tready.
  - Handshake with m_tlast=1:
    - last<=g; grant<=0; busy<=0; next state IDLE.
    - pkt_count<=pkt_count+1, wrapping from 2^CNT_W-1 to 0.
  - Handshake without tlast: stay in GRANT.
  - Granted master drops tvalid mid-packet: stay in GRANT (no timeout, no preemption). Other masters' tvalid is ignored.
- Fairness: one IDLE cycle always separates packets. At the release cycle, the just-served master is lowest priority in the next arbitration.
- Single-beat packets (tvalid & tlast on the first beat) are legal: GRANT lasts 1 cycle when m_tready=1.
- Back-pressure: m_tready low holds all data; no beat is dropped or duplicated. A beat is consumed only on handshake.
- Reset mid-packet:
  - Grant dropped, FSM to IDLE, pointer to N_MASTERS-1, pkt_count cleared.
  - The partial packet is abandoned; restarting it is the upstream's responsibility.
- No combinational path from s_tvalid to s_tready other than through the registered grant. m_tready→s_tready[g] is the only pass-through path.

Decomposition:
- Shared package axis_pkg:
  - AXIS_DATA_W default (32).
  - State enum constants ST_IDLE/ST_GRANT.
  - Max-masters constant (8).
- One sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N], last[log2N].
  - Outputs: one-hot gnt[N], any.
  - Implemented as a rotate + priority encode + rotate back.
- FSM, mux, and counter stay in axis_rr_arbiter.

Test Plan:
- Reset then only master 2 asserts tvalid with a 3-beat packet (0xA0, 0xA1, 0xA2+tlast), m_tready=1 → grant=4'b0100 one cycle later; m_tdata shows A0, A1, A2 on consecutive cycles; pkt_count=1; grant=0 afterwards.
- All 4 masters continuously send single-beat packets, m_tready=1 → grant order 0,1,2,3,0,1; every grant separated by one idle cycle; pkt_count=6 after six grants.
- Master 1 is granted mid-packet and m_tready is held low for 5 cycles → m_tdata stable; s_tready[1]=0 during the stall; no beat lost; beat count at output equals beats sent.
- Master 0 drops tvalid for 3 cycles mid-packet while master 3 requests → grant stays 4'b0001; s_tready[3]=0; master 3 is granted only after master 0's tlast handshake.
- areset asserted during the 2nd beat of a 4-beat packet from master 1 → next cycle grant=0, busy=0, pkt_count=0, m_tvalid=0; on release, a simultaneous request from masters 1 and 3 grants master 1.
- pkt_count preloaded to 0xFFFF by running 65535 packets (or CNT_W=4 variant with 15 packets) → next tlast handshake wraps the count to 0.
